fpu_cvt_writeback: RTL and testbench

- Downstream stage of the FP/integer conversion unit.
- Takes each conversion result together with its source operands and destination register.
- Derives the RISC-V exception flags (NV, NX) for each result and buffers results in a 2-entry FIFO with a valid/ready handshake.
- Presents results one at a time to the register-file writeback port and keeps the sticky fflags accumulator.

---
 rtl/fpu_pkg.sv | 36 +++
 rtl/fpu_cvt_flags.sv | 71 +++++++
 rtl/fpu_cvt_writeback.sv | 113 +++++++++++
 tb/tb_fpu_cvt_writeback.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FP/integer conversion writeback stage.
package fpu_pkg;

  localparam logic [4:0] OP_FCVT_S_W  = 5'b11001;
  localparam logic [4:0] OP_FCVT_S_WU = 5'b11010;
  localparam logic [4:0] OP_FCVT_W_S  = 5'b10110;
  localparam logic [4:0] OP_FCVT_WU_S = 5'b10111;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // Widest destination index an entry can hold; the top's RD_W must not exceed it.
  localparam int CVT_RD_W = 5;

  typedef struct packed {
    logic                is_fp;
    logic [CVT_RD_W-1:0] rd;
    logic [31:0]         data;
    logic [4:0]          flags;
  } cvt_wb_entry_t;

  // True for the four conversion op codes this stage handles.
  function automatic logic is_cvt_op(input logic [4:0] op);
    return (op == OP_FCVT_S_W) || (op == OP_FCVT_S_WU) ||
           (op == OP_FCVT_W_S) || (op == OP_FCVT_WU_S);
  endfunction

  // True when the result goes to the FP register file (int -> float).
  function automatic logic is_int_to_fp(input logic [4:0] op);
    return (op == OP_FCVT_S_W) || (op == OP_FCVT_S_WU);
  endfunction

endpackage

// File: rtl/fpu_cvt_flags.sv
// Combinational exception-flag classifier for one conversion result.
module fpu_cvt_flags
  import fpu_pkg::*;
(
  input  logic [4:0]  i_op,
  input  logic [31:0] i_operand_a,
  input  logic [31:0] i_rs1_f,
  output logic [4:0]  o_flags
);

  logic        sign;
  logic [7:0]  expo;
  logic [22:0] man;
  logic [7:0]  sh;
  logic        frac_nz;
  logic [31:0] mag;
  logic [4:0]  msb;
  logic [31:0] low_mask;
  logic        nv;
  logic        nx;

  // Classify the float source (float->int) or the integer magnitude (int->float).
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    o_flags  = '0;
    nv       = 1'b0;
    nx       = 1'b0;
    frac_nz  = 1'b0;
    msb      = '0;
    sign     = i_rs1_f[31];
    expo     = i_rs1_f[30:23];
    man      = i_rs1_f[22:0];
    sh       = expo - 8'd127;

    // Nonzero fraction bits below the binary point.
    if (expo < 8'd127) begin
      frac_nz = (expo != 8'd0) || (man != 23'd0);
    end else if (expo < 8'd150) begin
      frac_nz = |(man & (23'h7F_FFFF >> sh));
    end

    // Magnitude of the integer source and position of its leading one.
    mag = ((i_op == OP_FCVT_S_W) && i_operand_a[31]) ? (~i_operand_a + 32'd1) : i_operand_a;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) msb = 5'(i);
    end
    low_mask = (msb > 5'd23) ? ((32'd1 << (msb - 5'd23)) - 32'd1) : 32'd0;

    case (i_op)
      OP_FCVT_W_S: begin
        // -2^31 exactly is the only exponent-31 value that fits.
        nv = (expo == 8'hFF) || (expo > 8'd158) ||
             ((expo == 8'd158) && !(sign && (man == 23'd0)));
        nx = !nv && frac_nz;
      end
      OP_FCVT_WU_S: begin
        // Negative values with magnitude >= 1 are invalid; -1 < x < 0 only inexact.
        nv = (expo == 8'hFF) || (expo > 8'd158) || (sign && (expo >= 8'd127));
        nx = !nv && frac_nz;
      end
      OP_FCVT_S_W, OP_FCVT_S_WU: begin
        nx = |(mag & low_mask);
      end
      default: ;
    endcase

    o_flags[FLAG_NV] = nv;
    o_flags[FLAG_NX] = nx;
  end

endmodule

// File: rtl/fpu_cvt_writeback.sv
// Conversion writeback stage: flag classification, result FIFO, sticky fflags.
module fpu_cvt_writeback
  import fpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int RD_W  = 5
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_alu_op,
  input  logic [31:0]     i_operand_a,
  input  logic [31:0]     i_rs1_f,
  input  logic [31:0]     i_data_convert,
  input  logic [RD_W-1:0] i_rd_addr,
  output logic            o_wb_valid,
  input  logic            i_wb_ready,
  output logic            o_wb_is_fp,
  output logic [RD_W-1:0] o_wb_rd,
  output logic [31:0]     o_wb_data,
  output logic [4:0]      o_wb_flags,
  input  logic            i_fflags_clr,
  output logic [4:0]      o_fflags
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q, ready_d;
  logic [4:0]       fflags_q, fflags_d;
  cvt_wb_entry_t    mem_q [DEPTH];
  cvt_wb_entry_t    mem_d;
  cvt_wb_entry_t    head;
  cvt_wb_entry_t    head_vis;
  logic [4:0]       in_flags;
  logic             push;
  logic             pop;
  logic             empty;

  fpu_cvt_flags u_flags (
    .i_op        (i_alu_op),
    .i_operand_a (i_operand_a),
    .i_rs1_f     (i_rs1_f),
    .o_flags     (in_flags)
  );

  // Handshake, pointer/count and sticky-flag next-state logic.
  always_comb begin
    empty    = (count_q == '0);
    head     = mem_q[rd_ptr_q];
    push     = i_valid && ready_q && is_cvt_op(i_alu_op);
    pop      = !empty && i_wb_ready;

    mem_d       = '0;
    mem_d.is_fp = is_int_to_fp(i_alu_op);
    mem_d.rd    = CVT_RD_W'(i_rd_addr);
    mem_d.data  = i_data_convert;
    mem_d.flags = in_flags;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Ready comes from the next count so it is a flop, not a path from i_wb_ready.
    ready_d  = (count_d != CNT_W'(DEPTH));
    fflags_d = (i_fflags_clr ? 5'd0 : fflags_q) | (pop ? head.flags : 5'd0);
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      fflags_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      fflags_q <= fflags_d;
    end
  end

  // Entry storage written on accept.
  always_ff @(posedge i_clk) begin
    // NOTE: storage is not reset; the count alone decides which entries are live.
    if (push) mem_q[wr_ptr_q] <= mem_d;
  end

  // Head entry is forced to zero while the FIFO is empty.
  always_comb begin
    head_vis = empty ? '0 : head;
  end

  assign o_ready    = ready_q;
  assign o_wb_valid = !empty;
  assign o_wb_is_fp = head_vis.is_fp;
  assign o_wb_rd    = RD_W'(head_vis.rd);
  assign o_wb_data  = head_vis.data;
  assign o_wb_flags = head_vis.flags;
  assign o_fflags   = fflags_q;

endmodule

// File: tb/tb_fpu_cvt_writeback.sv
// Self-checking bench for fpu_cvt_writeback: directed steps then randomized traffic.
module tb_fpu_cvt_writeback;
  import fpu_pkg::*;

  localparam int DEPTH = 2;
  localparam int RD_W  = 5;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic            i_valid;
  logic            o_ready;
  logic [4:0]      i_alu_op;
  logic [31:0]     i_operand_a;
  logic [31:0]     i_rs1_f;
  logic [31:0]     i_data_convert;
  logic [RD_W-1:0] i_rd_addr;
  logic            o_wb_valid;
  logic            i_wb_ready;
  logic            o_wb_is_fp;
  logic [RD_W-1:0] o_wb_rd;
  logic [31:0]     o_wb_data;
  logic [4:0]      o_wb_flags;
  logic            i_fflags_clr;
  logic [4:0]      o_fflags;

  int n_checks = 0;
  int n_errors = 0;

  fpu_cvt_writeback #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_alu_op       (i_alu_op),
    .i_operand_a    (i_operand_a),
    .i_rs1_f        (i_rs1_f),
    .i_data_convert (i_data_convert),
    .i_rd_addr      (i_rd_addr),
    .o_wb_valid     (o_wb_valid),
    .i_wb_ready     (i_wb_ready),
    .o_wb_is_fp     (o_wb_is_fp),
    .o_wb_rd        (o_wb_rd),
    .o_wb_data      (o_wb_data),
    .o_wb_flags     (o_wb_flags),
    .i_fflags_clr   (i_fflags_clr),
    .o_fflags       (o_fflags)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] f,
                      input logic [31:0] data, input logic [4:0] rd);
    i_alu_op = op; i_operand_a = a; i_rs1_f = f; i_data_convert = data; i_rd_addr = rd;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic is_fp, input logic [4:0] rd,
                             input logic [31:0] data, input logic [4:0] flags);
    check({tag, "_valid"}, 32'(o_wb_valid), 32'd1);
    check({tag, "_is_fp"}, 32'(o_wb_is_fp), 32'(is_fp));
    check({tag, "_rd"},    32'(o_wb_rd),    32'(rd));
    check({tag, "_data"},  o_wb_data,       data);
    check({tag, "_flags"}, 32'(o_wb_flags), 32'(flags));
  endtask

  // Reference flags from the real value of the operand rather than bit fields.
  function automatic logic [4:0] model_flags(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] f);
    logic [4:0]      fl;
    real             v;
    int              e;
    longint unsigned mag;
    fl = '0;
    e  = int'(f[30:23]);
    if (e == 0) v = real'(f[22:0]) * (2.0 ** (-149.0));
    else        v = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
    if (f[31]) v = -v;
    mag = 64'(a);
    if (op == OP_FCVT_S_W && a[31]) mag = 64'h1_0000_0000 - 64'(a);
    if (op == OP_FCVT_W_S) begin
      if (e == 255 || v >= 2147483648.0 || v < -2147483648.0) fl[FLAG_NV] = 1'b1;
      else if (v != $floor(v))                                fl[FLAG_NX] = 1'b1;
    end else if (op == OP_FCVT_WU_S) begin
      if (e == 255 || v >= 4294967296.0 || v <= -1.0) fl[FLAG_NV] = 1'b1;
      else if (v != $floor(v))                         fl[FLAG_NX] = 1'b1;
    end else if (op == OP_FCVT_S_W || op == OP_FCVT_S_WU) begin
      // Exactly representable iff the odd part fits in a 24-bit significand.
      while (mag != 0 && mag[0] == 1'b0) mag = mag >> 1;
      if (mag >= 64'd16777216) fl[FLAG_NX] = 1'b1;
    end
    return fl;
  endfunction

  function automatic logic [31:0] rand_float();
    logic [7:0]  ex;
    logic [22:0] m;
    int          sel;
    sel = int'($urandom_range(0, 9));
    if (sel == 0)      ex = 8'hFF;
    else if (sel == 1) ex = 8'h00;
    else if (sel == 2) ex = 8'd158;
    else               ex = 8'($urandom_range(110, 165));
    m = 23'($urandom);
    if ($urandom_range(0, 2) == 0) m = m & (23'h7F_FFFF << $urandom_range(0, 23));
    if ($urandom_range(0, 7) == 0) m = '0;
    return {1'($urandom), ex, m};
  endfunction

  function automatic logic [31:0] rand_int();
    logic [31:0] v;
    v = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 0) v = v << $urandom_range(0, 16);
    return v;
  endfunction

  // Watchdog: the bench never waits on DUT events, but guard against a stuck clock.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cvt_wb_entry_t mq[$];
    cvt_wb_entry_t ent;
    cvt_wb_entry_t exp_head;
    logic [4:0]    mf;
    logic [4:0]    nf;
    logic          pop;
    logic          accept;
    logic          op_ok;

    i_rst_n = 1'b0; i_valid = 1'b0; i_alu_op = '0; i_operand_a = '0; i_rs1_f = '0;
    i_data_convert = '0; i_rd_addr = '0; i_wb_ready = 1'b0; i_fflags_clr = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;

    // Reset state
    check("rst_valid",  32'(o_wb_valid), 32'd0);
    check("rst_ready",  32'(o_ready),    32'd1);
    check("rst_fflags", 32'(o_fflags),   32'd0);
    check("rst_data",   o_wb_data,       32'd0);
    check("rst_rd",     32'(o_wb_rd),    32'd0);
    check("rst_flags",  32'(o_wb_flags), 32'd0);
    check("rst_is_fp",  32'(o_wb_is_fp), 32'd0);

    // W_S 1.5 -> NX, visible one edge after accept, then popped into fflags
    i_wb_ready = 1'b1;
    send(OP_FCVT_W_S, 32'd0, 32'h3FC0_0000, 32'd1, 5'd5);
    expect_head("ws_1p5", 1'b0, 5'd5, 32'd1, 5'h01);
    tick();
    check("ws_1p5_popped", 32'(o_wb_valid), 32'd0);
    check("ws_1p5_fflags", 32'(o_fflags),   32'h01);

    // Flag classification cases, each popped on the following edge
    send(OP_FCVT_W_S, 32'd0, 32'h7FC0_0000, 32'h7FFF_FFFF, 5'd6);
    expect_head("ws_nan", 1'b0, 5'd6, 32'h7FFF_FFFF, 5'h10);
    tick();
    send(OP_FCVT_WU_S, 32'd0, 32'hBF80_0000, 32'd0, 5'd7);
    expect_head("wus_m1", 1'b0, 5'd7, 32'd0, 5'h10);
    tick();
    send(OP_FCVT_WU_S, 32'd0, 32'hBF00_0000, 32'd0, 5'd8);
    expect_head("wus_m0p5", 1'b0, 5'd8, 32'd0, 5'h01);
    tick();
    send(OP_FCVT_S_W, 32'h0100_0001, 32'd0, 32'h4B80_0000, 5'd9);
    expect_head("sw_inexact", 1'b1, 5'd9, 32'h4B80_0000, 5'h01);
    tick();
    send(OP_FCVT_S_W, 32'h0100_0000, 32'd0, 32'h4B80_0000, 5'd10);
    expect_head("sw_exact", 1'b1, 5'd10, 32'h4B80_0000, 5'h00);
    tick();
    send(OP_FCVT_W_S, 32'd0, 32'hCF00_0000, 32'h8000_0000, 5'd11);
    expect_head("ws_min_int", 1'b0, 5'd11, 32'h8000_0000, 5'h00);
    tick();
    check("sticky_accum", 32'(o_fflags), 32'h11);
    i_fflags_clr = 1'b1;
    tick();
    i_fflags_clr = 1'b0;
    check("sticky_clr0", 32'(o_fflags), 32'h00);

    // Backpressure: three back-to-back valids, only two fit
    i_wb_ready = 1'b0;
    i_alu_op = OP_FCVT_W_S; i_rs1_f = 32'h3F80_0000; i_operand_a = '0; i_valid = 1'b1;
    i_rd_addr = 5'd1; i_data_convert = 32'hA1;
    tick();
    check("bp_ready_after1", 32'(o_ready), 32'd1);
    i_rd_addr = 5'd2; i_data_convert = 32'hA2;
    tick();
    check("bp_ready_after2", 32'(o_ready), 32'd0);
    i_rd_addr = 5'd3; i_data_convert = 32'hA3;
    tick();
    check("bp_ready_third", 32'(o_ready), 32'd0);
    expect_head("bp_head1", 1'b0, 5'd1, 32'hA1, 5'h00);
    i_wb_ready = 1'b1;
    tick();
    check("bp_ready_after_pop", 32'(o_ready), 32'd1);
    expect_head("bp_head2", 1'b0, 5'd2, 32'hA2, 5'h00);
    tick();
    i_valid = 1'b0;
    expect_head("bp_head3", 1'b0, 5'd3, 32'hA3, 5'h00);
    tick();
    check("bp_drained", 32'(o_wb_valid), 32'd0);

    // Clear and pop in the same cycle leave exactly the popped flags
    send(OP_FCVT_W_S, 32'd0, 32'h7FC0_0000, 32'd0, 5'd12);
    tick();
    i_wb_ready = 1'b0;
    send(OP_FCVT_W_S, 32'd0, 32'h3FC0_0000, 32'd1, 5'd13);
    check("clrpop_before", 32'(o_fflags), 32'h10);
    i_fflags_clr = 1'b1;
    i_wb_ready = 1'b1;
    tick();
    i_fflags_clr = 1'b0;
    i_wb_ready = 1'b0;
    check("clrpop_after", 32'(o_fflags), 32'h01);
    i_fflags_clr = 1'b1;
    tick();
    i_fflags_clr = 1'b0;
    check("clr_no_pop", 32'(o_fflags), 32'h00);

    // Reset mid-operation discards buffered entries and clears fflags
    i_wb_ready = 1'b1;
    send(OP_FCVT_W_S, 32'd0, 32'h7FC0_0000, 32'd0, 5'd14);
    tick();
    i_wb_ready = 1'b0;
    send(OP_FCVT_S_W, 32'd7, 32'd0, 32'd7, 5'd15);
    send(OP_FCVT_S_W, 32'd8, 32'd0, 32'd8, 5'd16);
    check("midrst_full", 32'(o_ready), 32'd0);
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    check("midrst_valid",  32'(o_wb_valid), 32'd0);
    check("midrst_fflags", 32'(o_fflags),   32'd0);
    check("midrst_ready",  32'(o_ready),    32'd1);
    i_wb_ready = 1'b1;
    tick();
    check("midrst_no_wb", 32'(o_wb_valid), 32'd0);

    // Unsupported op is accepted and dropped
    send(5'b00000, 32'h0100_0001, 32'h7FC0_0000, 32'd9, 5'd17);
    check("badop_valid", 32'(o_wb_valid), 32'd0);
    check("badop_ready", 32'(o_ready),    32'd1);
    tick();
    check("badop_fflags", 32'(o_fflags), 32'd0);

    // Randomized traffic against the queue model
    mf = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0:       i_alu_op = OP_FCVT_W_S;
        1:       i_alu_op = OP_FCVT_WU_S;
        2:       i_alu_op = OP_FCVT_S_W;
        3:       i_alu_op = OP_FCVT_S_WU;
        default: i_alu_op = 5'($urandom);
      endcase
      i_operand_a    = rand_int();
      i_rs1_f        = rand_float();
      i_data_convert = $urandom;
      i_rd_addr      = 5'($urandom);
      i_wb_ready     = ($urandom_range(0, 2) != 0);
      i_fflags_clr   = ($urandom_range(0, 15) == 0);

      exp_head = (mq.size() != 0) ? mq[0] : '0;
      check("rnd_ready",  32'(o_ready),    32'(mq.size() < DEPTH));
      check("rnd_valid",  32'(o_wb_valid), 32'(mq.size() != 0));
      check("rnd_is_fp",  32'(o_wb_is_fp), 32'(exp_head.is_fp));
      check("rnd_rd",     32'(o_wb_rd),    32'(exp_head.rd));
      check("rnd_data",   o_wb_data,       exp_head.data);
      check("rnd_flags",  32'(o_wb_flags), 32'(exp_head.flags));
      check("rnd_fflags", 32'(o_fflags),   32'(mf));

      op_ok  = (i_alu_op == OP_FCVT_W_S) || (i_alu_op == OP_FCVT_WU_S) ||
               (i_alu_op == OP_FCVT_S_W) || (i_alu_op == OP_FCVT_S_WU);
      pop    = (mq.size() != 0) && i_wb_ready;
      accept = i_valid && (mq.size() < DEPTH) && op_ok;
      nf     = (i_fflags_clr ? 5'd0 : mf) | (pop ? mq[0].flags : 5'd0);
      if (pop) void'(mq.pop_front());
      if (accept) begin
        ent.is_fp = (i_alu_op == OP_FCVT_S_W) || (i_alu_op == OP_FCVT_S_WU);
        ent.rd    = i_rd_addr;
        ent.data  = i_data_convert;
        ent.flags = model_flags(i_alu_op, i_operand_a, i_rs1_f);
        mq.push_back(ent);
      end
      mf = nf;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
